// File: rtl/gate_op_arbiter.sv
// Round-robin arbiter in front of one registered bitwise gate unit.
// Each result is tagged with the id of the requester that issued it.
module gate_op_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ*2-1:0]     req_op,
    output logic                     rsp_valid,
    output logic [IDW-1:0]           rsp_id,
    output logic [WIDTH-1:0]         rsp_data,
    input  logic                     rsp_ready,
    output logic                     busy,
    output logic [15:0]              txn_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [IDW-1:0]   ptr;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       op_q;
    logic [IDW-1:0]   id_q;

    logic [WIDTH-1:0] a_arr  [NUM_REQ];
    logic [WIDTH-1:0] b_arr  [NUM_REQ];
    logic [1:0]       op_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign a_arr[g]  = req_a[g*WIDTH +: WIDTH];
        assign b_arr[g]  = req_b[g*WIDTH +: WIDTH];
        assign op_arr[g] = req_op[g*2 +: 2];
    end

    logic           found;
    logic [IDW-1:0] pick;
    logic [IDW-1:0] cand;
    logic [IDW:0]   sum;
    logic [IDW-1:0] ptr_nxt;

    // First valid requester at or after ptr, wrapping modulo NUM_REQ
    always_comb begin
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NUM_REQ))
                sum = sum - (IDW+1)'(NUM_REQ);
            cand = sum[IDW-1:0];
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && state == IDLE && found)
            req_ready[pick] = 1'b1;
    end

    assign ptr_nxt = (pick == IDW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            id_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            busy      <= 1'b0;
            txn_count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        a_q   <= a_arr[pick];
                        b_q   <= b_arr[pick];
                        op_q  <= op_arr[pick];
                        id_q  <= pick;
                        ptr   <= ptr_nxt;
                        state <= EXEC;
                        busy  <= 1'b1;
                    end
                end
                EXEC: begin
                    unique case (op_q)
                        2'b00: rsp_data <= a_q & b_q;
                        2'b01: rsp_data <= a_q | b_q;
                        2'b10: rsp_data <= a_q ^ b_q;
                        2'b11: rsp_data <= ~(a_q & b_q);
                    endcase
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        txn_count <= txn_count + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_op_arbiter.sv
// Directed bench for gate_op_arbiter: opcodes, round-robin order,
// backpressure, mid-operation reset and counter wrap.
module tb_gate_op_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N*2-1:0] req_op;
    logic           rsp_valid;
    logic [IW-1:0]  rsp_id;
    logic [W-1:0]   rsp_data;
    logic           rsp_ready;
    logic           busy;
    logic [15:0]    txn_count;

    int n_tests = 0;
    int n_fail  = 0;

    gate_op_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .busy      (busy),
        .txn_count (txn_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a,
                           input logic [7:0] b, input logic [1:0] op);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_op[i*2 +: 2] = op;
    endtask

    // Mid-cycle reset: outputs must clear before any clock edge
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, " rst ready"}, req_ready, 0);
        chk({tag, " rst rsp_valid"}, rsp_valid, 0);
        chk({tag, " rst rsp_id"}, rsp_id, 0);
        chk({tag, " rst rsp_data"}, rsp_data, 0);
        chk({tag, " rst busy"}, busy, 0);
        chk({tag, " rst txn_count"}, txn_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // One full transaction with rsp_ready high, starting in IDLE
    task automatic txn(input string tag, input int id,
                       input logic [7:0] exp);
        #1;
        chk({tag, " grant"}, req_ready, 32'(1 << id));
        chk({tag, " idle busy"}, busy, 0);
        tick();
        chk({tag, " exec busy"}, busy, 1);
        chk({tag, " exec ready"}, req_ready, 0);
        chk({tag, " exec rsp_valid"}, rsp_valid, 0);
        tick();
        chk({tag, " rsp_valid"}, rsp_valid, 1);
        chk({tag, " rsp_id"}, rsp_id, id);
        chk({tag, " rsp_data"}, rsp_data, exp);
        tick();
        chk({tag, " done rsp_valid"}, rsp_valid, 0);
    endtask

    initial begin
        rst_n     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b1;
        set_req(0, 8'h11, 8'hFF, 2'b00);
        set_req(1, 8'h22, 8'hFF, 2'b01);
        set_req(2, 8'h44, 8'hFF, 2'b10);
        set_req(3, 8'h88, 8'hFF, 2'b11);

        repeat (2) @(posedge clk);
        #3;
        do_reset("init");
        repeat (3) tick();
        chk("idle busy", busy, 0);
        chk("idle ready", req_ready, 0);
        chk("idle rsp_valid", rsp_valid, 0);

        // Requester 2 alone, every opcode
        set_req(2, 8'hCA, 8'h5F, 2'b00);
        req_valid = 4'b0100;
        txn("and", 2, 8'h4A);
        req_op[5:4] = 2'b01;
        txn("or", 2, 8'hDF);
        req_op[5:4] = 2'b10;
        txn("xor", 2, 8'h95);
        req_op[5:4] = 2'b11;
        txn("nand", 2, 8'hB5);
        req_valid = '0;
        chk("op count", txn_count, 4);
        set_req(2, 8'h44, 8'hFF, 2'b10);

        // All requesters valid: strict rotation from ptr=0
        #2;
        do_reset("rr");
        req_valid = 4'b1111;
        txn("rr0", 0, 8'h11);
        txn("rr1", 1, 8'hFF);
        txn("rr2", 2, 8'hBB);
        txn("rr3", 3, 8'h77);
        txn("rr4", 0, 8'h11);
        txn("rr5", 1, 8'hFF);
        req_valid = '0;
        chk("rr count", txn_count, 6);

        // Only 1 and 3: pointer skips idle slots and wraps
        #2;
        do_reset("skip");
        req_valid = 4'b1010;
        txn("sk0", 1, 8'hFF);
        txn("sk1", 3, 8'h77);
        txn("sk2", 1, 8'hFF);
        txn("sk3", 3, 8'h77);
        req_valid = 4'b0001;
        txn("sk4", 0, 8'h11);
        req_valid = '0;
        chk("skip count", txn_count, 5);

        // Backpressure: hold RESP, then release
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        #1;
        chk("bp grant", req_ready, 1);
        tick();
        tick();
        for (int k = 0; k < 10; k++) begin
            chk("bp rsp_valid", rsp_valid, 1);
            chk("bp rsp_id", rsp_id, 0);
            chk("bp rsp_data", rsp_data, 8'h11);
            chk("bp ready", req_ready, 0);
            chk("bp busy", busy, 1);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp idle rsp_valid", rsp_valid, 0);
        chk("bp idle busy", busy, 0);
        chk("bp regrant", req_ready, 1);
        chk("bp count1", txn_count, 6);
        tick();
        chk("bp exec busy", busy, 1);
        tick();
        tick();
        req_valid = '0;
        chk("bp count2", txn_count, 7);

        // Reset during EXEC discards the transaction
        req_valid = 4'b0010;
        #1;
        chk("mid grant", req_ready, 2);
        tick();
        chk("mid exec busy", busy, 1);
        req_valid = '0;
        #2;
        do_reset("mid");
        for (int k = 0; k < 4; k++) begin
            chk("mid no rsp", rsp_valid, 0);
            chk("mid count", txn_count, 0);
            tick();
        end

        // Counter wrap: preload near the top, then complete two
        force dut.txn_count = 16'hFFFE;
        #1;
        release dut.txn_count;
        #1;
        chk("wrap preload", txn_count, 16'hFFFE);
        req_valid = 4'b0001;
        txn("wr0", 0, 8'h11);
        chk("wrap ffff", txn_count, 16'hFFFF);
        txn("wr1", 0, 8'h11);
        chk("wrap zero", txn_count, 16'h0000);
        req_valid = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_op_arbiter.md
Name: gate_op_arbiter

Overview:
- Shares one registered bitwise gate unit (AND/OR/XOR/NAND over WIDTH-bit operands) among NUM_REQ requesters.
- Requesters are served in round-robin order, with a valid/ready handshake on each requester and a single valid/ready response channel.
- Sits between requester blocks and the shared gate datapath.
- Serialises access and tags each result with the id of the requester that issued it.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- WIDTH, 8: operand and result width in bits, 1..32.
- IDW, $clog2(NUM_REQ): width of the requester id.

Ports:
- clk  in  1  single clock for the whole block; rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  bit i: requester i presents an operation.
- req_ready  out  NUM_REQ  bit i: arbiter accepts requester i this cycle; one-hot or zero.
- req_a  in  NUM_REQ*WIDTH  operand A; slice i belongs to requester i.
- req_b  in  NUM_REQ*WIDTH  operand B; slice i belongs to requester i.
- req_op  in  NUM_REQ*2  opcode; slice i belongs to requester i. 00=AND, 01=OR, 10=XOR, 11=NAND.
- rsp_valid  out  1  result is available.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_data  out  WIDTH  result.
- rsp_ready  in  1  consumer takes the result.
- busy  out  1  high whenever the state is not IDLE.
- txn_count  out  16  number of completed responses; wraps from 0xFFFF to 0.

Behaviour:
- Reset (rst_n low, asynchronous) sets all of the following immediately:
  - state=IDLE, ptr=0, req_ready=0, rsp_valid=0.
  - rsp_id=0, rsp_data=0, busy=0, txn_count=0.
  - Internal operand, opcode and id registers=0.
- State machine:
  - IDLE -> EXEC on an accept.
  - EXEC -> RESP unconditionally.
  - RESP -> IDLE when rsp_ready=1.
- IDLE:
  - Combinational round-robin pick: the first i with req_valid[i]=1, searching ptr, ptr+1, ..., wrapping modulo NUM_REQ.
  - req_ready is one-hot at the picked index, or 0 if no request is valid.
  - Accept = req_valid[i] & req_ready[i]. On accept, latch a/b/op slice i and id=i, and set ptr=(i+1) mod NUM_REQ.
- EXEC:
  - req_ready=0.
  - The result register loads op(a,b): AND a&b, OR a|b, XOR a^b, NAND ~(a&b), all bitwise over WIDTH bits.
- RESP:
  - rsp_valid=1. rsp_id and rsp_data are held stable until rsp_ready=1.
  - On rsp_valid & rsp_ready: txn_count increments and the state returns to IDLE.
  - rsp_valid drops the following cycle unless it is re-entered.
- req_ready is low in EXEC and RESP, so no new accept happens while a transaction is in flight.
- Latency and throughput:
  - Accept edge to rsp_valid high is 2 cycles.
  - Minimum issue interval is 3 cycles when rsp_ready is tied high.
- Requester rules:
  - Must hold valid, a, b and op stable until accepted.
  - May drop valid before acceptance; it then loses its turn with no side effect.
- Fairness: a requester that stays valid is served within NUM_REQ grants.
- ptr moves only on accept. No-request cycles leave it unchanged.
- All req_valid zero in IDLE: remain in IDLE with all outputs idle.
- Backpressure: rsp_ready held low keeps the state in RESP indefinitely with outputs stable, and all requesters stall.
- Reset mid-operation (EXEC or RESP): the transaction is discarded, no response is emitted, and txn_count is not incremented.
- txn_count at 0xFFFF wraps to 0x0000 on the next completion.

Test Plan:
- Reset state:
  - Stimulus: assert rst_n=0 in mid-cycle.
  - Required response: all outputs 0 immediately.
  - Stimulus: release reset with no requests.
  - Required response: busy=0, req_ready=0 indefinitely.
- Single requester, all four opcodes:
  - Stimulus: requester 2 with a=0xCA, b=0x5F, rsp_ready=1, ops 00/01/10/11 in turn.
  - Required response: rsp_data 0x4A/0xDF/0x95/0xB5, rsp_id=2.
  - Required response: rsp_valid 2 cycles after each accept; txn_count=4.
- Round-robin fairness:
  - Stimulus: all 4 requesters hold valid continuously, each with a distinct operand.
  - Required response: grant order 0,1,2,3,0,1. Each response carries the matching id and data.
- Pointer skip and wrap:
  - Stimulus: only requesters 1 and 3 valid, ptr initially 0.
  - Required response: grant order 1,3,1,3.
  - Stimulus: then only requester 0 valid.
  - Required response: it is granted next.
- Backpressure:
  - Stimulus: rsp_ready=0 for 10 cycles in RESP, with requester 0 valid.
  - Required response: rsp_id and rsp_data stable, req_ready=0 throughout.
  - Stimulus: rsp_ready=1 for one cycle.
  - Required response: IDLE, then requester 0 is accepted the next cycle.
- Reset mid-op and counter wrap:
  - Stimulus: assert rst_n=0 during EXEC.
  - Required response: no response is emitted and txn_count=0.
  - Stimulus: complete 65536 transactions.
  - Required response: txn_count=0.
